// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - reassembles UART bytes MSB-first into 32-bit words
//
// Collects one byte per Rx_Done pulse. The first byte of a word lands in
// word_out[31:24]. A finished word is presented on word_out with a one-cycle
// word_valid pulse. If the gap between bytes of one word grows too long, the
// partial word is dropped and timeout_err pulses, so the link resynchronises
// after a lost byte.
//
// Optional feature macro: UART_ASM_CHECKSUM_EN
//   When defined, a fifth byte equal to the XOR of the four data bytes is
//   required. A mismatch raises chk_err instead of word_valid.
//
// Ports:
//   Clk          system clock, all logic on posedge
//   Rst_n        synchronous active-low reset
//   Rx_Done      one-cycle pulse: rx_data holds a new byte
//   rx_data      received byte, sampled only when Rx_Done=1
//   word_out     last complete word, held until the next word completes
//   word_valid   one-cycle pulse: word_out has just been updated
//   busy         1 while a word is partially received
//   timeout_err  one-cycle pulse: partial word discarded by timeout
//   chk_err      one-cycle pulse on checksum mismatch (0 without the macro)

module uart_word_assembler #(
   parameter int TIMEOUT_CYCLES = 8680,
   parameter int CNT_W          = 14
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Rx_Done,
   input  logic [7:0]  rx_data,
   output logic [31:0] word_out,
   output logic        word_valid,
   output logic        busy,
   output logic        timeout_err,
   output logic        chk_err
);

   typedef enum logic [2:0] {
      IDLE,
      GOT1,
      GOT2,
`ifdef UART_ASM_CHECKSUM_EN
      GOT3,
      GOT4
`else
      GOT3
`endif
   } state_t;

   // Without the checksum only three bytes must be held: the fourth byte
   // goes straight from rx_data into word_out.
`ifdef UART_ASM_CHECKSUM_EN
   localparam int SH_W = 32;
`else
   localparam int SH_W = 24;
`endif

   localparam bit             TMO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TERM = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t            state_q, state_d;
   logic [SH_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic              word_valid_q, word_valid_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;
   logic              tmo_fire;

`ifdef UART_ASM_CHECKSUM_EN
   logic              chk_err_q, chk_err_d;
   logic [7:0]        xor_sum;
   assign xor_sum = shift_q[31:24] ^ shift_q[23:16] ^ shift_q[15:8] ^ shift_q[7:0];
`endif

   // A byte arriving on the terminal-count cycle wins over the timeout.
   assign tmo_fire = TMO_EN && (state_q != IDLE) && (cnt_q == TERM) && !Rx_Done;

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      word_d        = word_q;
      word_valid_d  = 1'b0;
      timeout_err_d = 1'b0;
`ifdef UART_ASM_CHECKSUM_EN
      chk_err_d     = 1'b0;
`endif
      if (Rx_Done) begin
         shift_d = {shift_q[SH_W-9:0], rx_data};
         cnt_d   = '0;
         case (state_q)
            IDLE: state_d = GOT1;
            GOT1: state_d = GOT2;
            GOT2: state_d = GOT3;
`ifdef UART_ASM_CHECKSUM_EN
            GOT3: state_d = GOT4;
            GOT4: begin
               // shift_q holds the four data bytes; rx_data is the checksum.
               state_d = IDLE;
               if (rx_data == xor_sum) begin
                  word_d       = shift_q;
                  word_valid_d = 1'b1;
               end else begin
                  chk_err_d = 1'b1;
               end
            end
`else
            GOT3: begin
               state_d      = IDLE;
               word_d       = {shift_q, rx_data};
               word_valid_d = 1'b1;
            end
`endif
            default: state_d = IDLE;
         endcase
      end else if (tmo_fire) begin
         state_d       = IDLE;
         shift_d       = '0;
         cnt_d         = '0;
         timeout_err_d = 1'b1;
      end else if (TMO_EN && (state_q != IDLE)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q       <= IDLE;
         shift_q       <= '0;
         cnt_q         <= '0;
         word_q        <= '0;
         word_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef UART_ASM_CHECKSUM_EN
         chk_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         word_q        <= word_d;
         word_valid_q  <= word_valid_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
`ifdef UART_ASM_CHECKSUM_EN
         chk_err_q     <= chk_err_d;
`endif
      end
   end

   assign word_out    = word_q;
   assign word_valid  = word_valid_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
`ifdef UART_ASM_CHECKSUM_EN
   assign chk_err     = chk_err_q;
`else
   assign chk_err     = 1'b0;
`endif

endmodule
